// File: rtl/hazard_unit_mc.sv
// Multi-cycle load-use hazard detector between ID and EX, with data-memory miss freeze.
// Optional stall statistics are built when HAZARD_STATS_EN is defined.

module hazard_src_cmp #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic              used,
  input  logic [ADDR_W-1:0] rd,
  output logic              hit
);
  assign hit = used && (rs == rd);
endmodule

module hazard_unit_mc #(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 3,
  parameter int STAT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] RS1addr_ID_i,
  input  logic [ADDR_W-1:0] RS2addr_ID_i,
  input  logic              RS1Used_ID_i,
  input  logic              RS2Used_ID_i,
  input  logic [ADDR_W-1:0] RDaddr_EX_i,
  input  logic              MemRead_EX_i,
  input  logic              MemStall_i,
  output logic              PCWrite_o,
  output logic              Stall_o,
  output logic              NoOp_o,
  output logic              Freeze_o,
  output logic [STAT_W-1:0] StallCycles_o,
  output logic [STAT_W-1:0] LoadUseEvents_o
);
  localparam int NUM_SRC = 2;

  typedef enum logic {IDLE = 1'b0, LOAD_WAIT = 1'b1} state_t;

  state_t                           state, state_nxt;
  logic [CNT_W-1:0]                 cnt, cnt_nxt;
  logic [NUM_SRC-1:0][ADDR_W-1:0]   rs_addr;
  logic [NUM_SRC-1:0]               rs_used;
  logic [NUM_SRC-1:0]               rs_hit;
  logic                             hazard;
  logic                             detect;

  assign rs_addr = {RS2addr_ID_i, RS1addr_ID_i};
  assign rs_used = {RS2Used_ID_i, RS1Used_ID_i};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_cmp #(.ADDR_W(ADDR_W)) u_cmp (
      .rs   (rs_addr[i]),
      .used (rs_used[i]),
      .rd   (RDaddr_EX_i),
      .hit  (rs_hit[i])
    );
  end

  // x0 is never a real producer, so it cannot create a hazard
  assign hazard = MemRead_EX_i && (RDaddr_EX_i != '0) && (|rs_hit);
  assign detect = (state == IDLE) && hazard && !MemStall_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A miss freezes everything, including the bubble countdown
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!MemStall_i) begin
      case (state)
        IDLE: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state_nxt = LOAD_WAIT;
            cnt_nxt   = CNT_W'(LOAD_LAT - 1);
          end
        end
        LOAD_WAIT: begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Reset forces nominal controls even though the state flops clear asynchronously
  always_comb begin
    PCWrite_o = 1'b1;
    Stall_o   = 1'b0;
    NoOp_o    = 1'b0;
    Freeze_o  = 1'b0;
    if (rst_i) begin
      if (MemStall_i) begin
        PCWrite_o = 1'b0;
        Stall_o   = 1'b1;
        Freeze_o  = 1'b1;
      end else if (detect || (state == LOAD_WAIT)) begin
        PCWrite_o = 1'b0;
        Stall_o   = 1'b1;
        NoOp_o    = 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cycles;
  logic [STAT_W-1:0] load_use_events;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cycles    <= '0;
      load_use_events <= '0;
    end else begin
      if (Stall_o && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STAT_W'(1);
      if (detect && (load_use_events != '1))
        load_use_events <= load_use_events + STAT_W'(1);
    end
  end

  assign StallCycles_o   = stall_cycles;
  assign LoadUseEvents_o = load_use_events;
`else
  assign StallCycles_o   = '0;
  assign LoadUseEvents_o = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: LOAD_LAT=1 and LOAD_LAT=3 (narrow stats) instances share stimulus
// and are checked every cycle against a bubble-budget model plus literal scenario totals.

module tb_hazard_unit_mc;
  logic       clk, rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, ms;

  logic [1:0]  pcw, stl, nop, frz;
  logic [31:0] sc1, ev1;
  logic [3:0]  sc3, ev3;

  hazard_unit_mc #(.ADDR_W(5), .LOAD_LAT(1), .CNT_W(3), .STAT_W(32)) u_d1 (
    .clk_i(clk), .rst_i(rst_n),
    .RS1addr_ID_i(rs1), .RS2addr_ID_i(rs2), .RS1Used_ID_i(u1), .RS2Used_ID_i(u2),
    .RDaddr_EX_i(rd), .MemRead_EX_i(mr), .MemStall_i(ms),
    .PCWrite_o(pcw[0]), .Stall_o(stl[0]), .NoOp_o(nop[0]), .Freeze_o(frz[0]),
    .StallCycles_o(sc1), .LoadUseEvents_o(ev1)
  );

  hazard_unit_mc #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(3), .STAT_W(4)) u_d3 (
    .clk_i(clk), .rst_i(rst_n),
    .RS1addr_ID_i(rs1), .RS2addr_ID_i(rs2), .RS1Used_ID_i(u1), .RS2Used_ID_i(u2),
    .RDaddr_EX_i(rd), .MemRead_EX_i(mr), .MemStall_i(ms),
    .PCWrite_o(pcw[1]), .Stall_o(stl[1]), .NoOp_o(nop[1]), .Freeze_o(frz[1]),
    .StallCycles_o(sc3), .LoadUseEvents_o(ev3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int     nchk = 0, nerr = 0, cyc = 0;
  int     rem[2];
  longint msc[2], mev[2];
  longint nop_tot[2], frz_tot[2];
  int     lat[2];
  longint maxv[2];

  int     lit_req = 0, lit_ack = 0, lit_id = 0;
  longint lit_act = 0, lit_exp = 0;
  bit     done = 1'b0;

  function automatic string lit_name(int id);
    case (id)
      0: return "lat1_bubbles";      1: return "lat3_bubbles";
      2: return "lat3_events";       3: return "lat3_stallcyc";
      4: return "filter_bubbles";    5: return "miss_bubbles_lat3";
      6: return "miss_freeze_lat3";  7: return "simul_bubbles_lat3";
      8: return "simul_freeze_lat3"; 9: return "simul_bubbles_lat1";
      10: return "rst_stall";        11: return "rst_stats";
      12: return "post_rst_bubbles"; 13: return "b2b_bubbles_lat3";
      14: return "b2b_bubbles_lat1"; 15: return "miss_bubbles_lat1";
      default: return "lit";
    endcase
  endfunction

  task automatic chk(input string n, input int k, input longint a, input longint e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s[%0d] @%0t: got %0d expected %0d", n, k, $time, a, e);
    end
  endtask

  initial begin
    lat[0] = 1;  maxv[0] = 64'hFFFF_FFFF;
    lat[1] = 3;  maxv[1] = 64'd15;
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; msc[k] = 0; mev[k] = 0; nop_tot[k] = 0; frz_tot[k] = 0;
    end
  end

  // Model: each detection grants a budget of LOAD_LAT non-frozen bubble cycles
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      logic       h;
      logic [3:0] e, a;
      longint     asc, aev;
      h = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (!rst_n) begin rem[k] = 0; msc[k] = 0; mev[k] = 0; end
      if (!rst_n)                e = 4'b1000;
      else if (ms)               e = 4'b0101;
      else if (rem[k] > 0 || h)  e = 4'b0110;
      else                       e = 4'b1000;
      a   = {pcw[k], stl[k], nop[k], frz[k]};
      asc = (k == 0) ? longint'(sc1) : longint'(sc3);
      aev = (k == 0) ? longint'(ev1) : longint'(ev3);
      chk("ctrl{pcw,stall,noop,freeze}", k, longint'(a), longint'(e));
      chk("stall_cycles", k, asc, STATS ? msc[k] : 0);
      chk("load_use_events", k, aev, STATS ? mev[k] : 0);
      nop_tot[k] += longint'(nop[k]);
      frz_tot[k] += longint'(frz[k]);
      if (rst_n) begin
        if (e[2] && msc[k] != maxv[k]) msc[k]++;
        if (!ms) begin
          if (rem[k] > 0) rem[k]--;
          else if (h) begin
            rem[k] = lat[k] - 1;
            if (mev[k] != maxv[k]) mev[k]++;
          end
        end
      end
    end
    if (lit_req != lit_ack) begin
      chk(lit_name(lit_id), 0, lit_act, lit_exp);
      lit_ack = lit_req;
    end
    if (done) begin
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
    end
    if (cyc > 50000) begin
      $display("FAIL watchdog: got %0d cycles expected completion", cyc);
      $fatal(1, "watchdog");
    end
  end

  task automatic step(input logic [4:0] a1, a2, d, input logic f1, f2, m, s);
    rs1 = a1; rs2 = a2; rd = d; u1 = f1; u2 = f2; mr = m; ms = s;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic haz(input logic s);
    step(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, s);
  endtask

  task automatic lit(input int id, input longint a, input longint e);
    lit_id = id; lit_act = a; lit_exp = e; lit_req++;
    @(posedge clk); #1;
  endtask

  initial begin
    longint b0, b1, f1v, rs_s, rs_t;
    rst_n = 1'b0;
    // hazard inputs held during reset must not leak through
    haz(1'b0); haz(1'b0); haz(1'b0);
    rst_n = 1'b1;
    idle(2);

    b0 = nop_tot[0]; b1 = nop_tot[1];
    haz(1'b0); idle(4);
    lit(0, nop_tot[0] - b0, 1);
    lit(1, nop_tot[1] - b1, 3);
    lit(2, longint'(ev3), STATS ? 1 : 0);
    lit(3, longint'(sc3), STATS ? 3 : 0);

    b0 = nop_tot[0] + nop_tot[1];
    step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    step(5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    lit(4, nop_tot[0] + nop_tot[1] - b0, 0);

    b0 = nop_tot[0]; b1 = nop_tot[1]; f1v = frz_tot[1];
    haz(1'b0); idle(1);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    b1 = nop_tot[1] - b1;
    lit(5, b1 - 0, 3);
    lit(6, frz_tot[1] - f1v, 2);
    lit(15, nop_tot[0] - b0, 1);

    b0 = nop_tot[0]; b1 = nop_tot[1]; f1v = frz_tot[1];
    haz(1'b1); haz(1'b1); haz(1'b0); idle(4);
    lit(7, nop_tot[1] - b1, 3);
    lit(8, frz_tot[1] - f1v, 2);
    lit(9, nop_tot[0] - b0, 1);

    b0 = nop_tot[0]; b1 = nop_tot[1];
    haz(1'b0); idle(2); haz(1'b0); idle(4);
    lit(13, nop_tot[1] - b1, 6);
    lit(14, nop_tot[0] - b0, 2);

    haz(1'b0);
    rst_n = 1'b0;
    #2;
    rs_s = longint'(stl[1]);
    rs_t = longint'(sc3) + longint'(ev3) + longint'(sc1) + longint'(ev1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    b1 = nop_tot[1];
    idle(4);
    lit(10, rs_s, 0);
    lit(11, rs_t, 0);
    lit(12, nop_tot[1] - b1, 0);

    for (int i = 0; i < 2500; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
    end
    rst_n = 1'b1;
    idle(2);
    done = 1'b1;
  end
endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised load-use hazard detector for the 5-stage pipeline, successor to the single-bubble ID-stage detector. It sits between ID and EX. It compares the ID-stage source registers against the EX-stage destination and stalls for a configurable number of cycles. This covers data memories with more than one cycle of load latency. It also freezes the whole pipeline while the data memory reports a miss, ignores x0 and unused operands, and optionally keeps stall statistics.

## Interface
Parameters:
- ADDR_W, 5: register address width.
- LOAD_LAT, 1: bubbles required per load-use hazard. Legal range 1..7.
- CNT_W, 3: width of the bubble counter. Must hold LOAD_LAT-1.
- STAT_W, 32: width of the statistics counters.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- RS1addr_ID_i  in  ADDR_W  rs1 of the instruction in ID.
- RS2addr_ID_i  in  ADDR_W  rs2 of the instruction in ID.
- RS1Used_ID_i  in  1  ID instruction reads rs1.
- RS2Used_ID_i  in  1  ID instruction reads rs2.
- RDaddr_EX_i  in  ADDR_W  rd of the instruction in EX.
- MemRead_EX_i  in  1  instruction in EX is a load.
- MemStall_i  in  1  data memory busy (miss in progress).
- PCWrite_o  out  1  PC update enable.
- Stall_o  out  1  hold IF/ID register.
- NoOp_o  out  1  inject bubble into ID/EX.
- Freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB registers.
- StallCycles_o  out  STAT_W  count of cycles with Stall_o=1.
- LoadUseEvents_o  out  STAT_W  count of detected load-use hazards.

## Operation
- Hazard term H: MemRead_EX_i && RDaddr_EX_i!=0 && ((RS1Used_ID_i && RS1addr_ID_i==RDaddr_EX_i) || (RS2Used_ID_i && RS2addr_ID_i==RDaddr_EX_i)).
- FSM states are IDLE and LOAD_WAIT. A CNT_W-bit counter cnt runs alongside.
- Priority 1, MemStall_i=1 in any state:
  - Outputs: PCWrite_o=0, Stall_o=1, NoOp_o=0, Freeze_o=1.
  - State, cnt and H-evaluation are held.
- Priority 2, IDLE with H=1:
  - Outputs: PCWrite_o=0, Stall_o=1, NoOp_o=1, Freeze_o=0.
  - If LOAD_LAT>1: next state LOAD_WAIT, cnt<=LOAD_LAT-1.
  - If LOAD_LAT=1: stay in IDLE.
- Priority 3, LOAD_WAIT:
  - Outputs same as priority 2. EX inputs are ignored because EX holds a bubble.
  - Each non-frozen cycle, cnt<=cnt-1. When cnt==1, next state is IDLE.
- Otherwise: PCWrite_o=1, Stall_o=0, NoOp_o=0, Freeze_o=0.
- Outputs are combinational from state and inputs (Mealy), so detection takes effect in the same cycle.

## Timing
- rst_i low, asynchronous: state=IDLE, cnt=0, statistics=0.
  - While rst_i is low, outputs are forced to PCWrite_o=1, Stall_o=0, NoOp_o=0, Freeze_o=0 regardless of inputs.
- Reset asserted mid-LOAD_WAIT aborts the stall immediately.
- A load-use hazard produces exactly LOAD_LAT consecutive non-frozen cycles with NoOp_o=1. The first of these is the detection cycle.
- MemStall_i cycles inside a hazard window extend it. They do not consume bubble count.
- MemStall_i and H in the same IDLE cycle: freeze wins and no bubble is injected. H is re-evaluated on the first cycle after MemStall_i falls, because the pipeline contents are unchanged.
- Back-to-back hazard, where a new load-use appears on the cycle after returning to IDLE: detected normally, no dead cycle.
- RDaddr_EX_i==0 or both Used flags low: never a hazard.

## Configuration
- HAZARD_STATS_EN defined:
  - StallCycles_o increments on every clock with Stall_o=1.
  - LoadUseEvents_o increments on each IDLE cycle with H=1 and MemStall_i=0.
  - Both counters saturate at 2^STAT_W-1 and are cleared by reset.
- HAZARD_STATS_EN undefined: both ports are driven constant 0 and no counter flops are built.

## Test plan
- Load-use on rs1 with LOAD_LAT=1: EX lw x5 (MemRead=1, RD=5), ID RS1=5, RS1Used=1 -> one cycle of PCWrite_o=0, Stall_o=1, NoOp_o=1, then nominal.
- LOAD_LAT=3, same stimulus -> exactly 3 consecutive NoOp_o=1 cycles, state returns to IDLE, LoadUseEvents_o=1, StallCycles_o=3 (stats build).
- False-hazard filter: RD=0 with RS1=0, or RD=7 with RS2=7 and RS2Used=0 -> outputs stay nominal throughout.
- Miss inside window, LOAD_LAT=3: MemStall_i=1 for 2 cycles after the first bubble -> Freeze_o=1 and NoOp_o=0 during the miss, then 2 further bubbles; 3 bubbles total.
- Simultaneous MemStall_i and H -> Freeze_o=1 with NoOp_o=0; after MemStall_i drops, bubbles are issued as normal.
- Reset mid-LOAD_WAIT: assert rst_i=0 during the second bubble -> outputs nominal immediately, statistics 0; after release, no residual stall.
